tst_seq_ctrl: RTL
=================

Name: tst_seq_ctrl

Overview:
Test-flow sequencer for one DUT site. On a handler start-of-test it runs power-up, loopback, checksum and level phases in order, and starts each sub-test engine with a one-cycle GO pulse. It supervises every phase with a timeout, drives the DUT supply enables, then presents a one-hot bin and an EOT pulse to the handler. It sits between the handler interface and the loopback, checksum and level-measure engines.

Parameters:
TMO_W, 24, width of the shared phase/settle counter
PH_TMO, 24'hFF_FFFF, cycles allowed per test phase before timeout
PWR_SETTLE, 24'h00_3FFF, cycles V1ON/V2ON are held before loopback starts
BIN_SETUP, 24'h00_0040, cycles bins are stable before EOT rises
EOT_LEN, 24'h07_FFFF, EOT high duration in cycles

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
SOT  in  1  handler start-of-test, level; rising edge starts a test
LPBK_GO  out  1  one-cycle start pulse to the loopback engine
LPBK_DN  in  1  loopback done, single-cycle pulse
LPBK_OK  in  1  loopback result, valid with LPBK_DN
CHK_GO  out  1  checksum start pulse
CHK_DN  in  1  checksum done pulse
CHK_OK  in  1  checksum result, valid with CHK_DN
LVL_GO  out  1  level-test start pulse
LVL_DN  in  1  level done pulse
LVL_OK  in  1  level result, valid with LVL_DN
V1ON  out  1  DUT supply 1 enable
V2ON  out  1  DUT supply 2 enable
BIN  out  5  one-hot: [0] pass, [1] loopback fail, [2] checksum fail, [3] level fail, [4] timeout
EOT  out  1  end-of-test to handler
BUSY  out  1  high in every state except IDLE
STATE  out  3  current state encoding, for debug

Behaviour:
- All outputs are registered. Reset values: STATE=IDLE, BIN=0, EOT=0, V1ON=0, V2ON=0, all GO outputs=0, BUSY=0.
- SOT passes through a 2-flop synchroniser and then an edge detector. A rising edge seen in IDLE moves to PWR on the next clock. SOT edges in any other state are ignored and are not queued.
- One TMO_W-bit counter is shared by all timed states. It loads 0 on every state entry and increments by 1 each cycle.
- State encoding: IDLE=0, PWR=1, LPBK=2, CHK=3, LVL=4, REPORT=5, EOTS=6.
- IDLE: V1ON=V2ON=0. BIN keeps the previous result. Entering PWR clears BIN to 0.
- PWR: V1ON=V2ON=1. When the counter reaches PWR_SETTLE-1, go to LPBK.
- LPBK: LPBK_GO is high in the first cycle of the state only.
  - LPBK_DN with LPBK_OK=1 -> CHK.
  - LPBK_DN with LPBK_OK=0 -> REPORT, fail code = loopback.
- CHK: V2ON=0, V1ON=1. CHK_GO pulses in the first cycle. DN/OK handling as for LPBK; pass -> LVL, fail code = checksum.
- LVL: V1ON=V2ON=1. LVL_GO pulses in the first cycle. Pass -> REPORT with code pass; fail code = level.
- Timeout: in LPBK, CHK or LVL, the counter reaching PH_TMO-1 -> REPORT with code timeout.
  - If DN and timeout occur in the same cycle, DN wins.
- DN pulses arriving in a state that does not own them are ignored.
- REPORT: V1ON=V2ON=0. BIN loads the one-hot code on the entry cycle. After BIN_SETUP cycles -> EOTS.
- EOTS: EOT=1 for exactly EOT_LEN cycles, then IDLE with EOT=0. BIN stays stable until the next accepted SOT.
- Exactly one BIN bit is set whenever BIN is non-zero.
- RST mid-test: every output returns to its reset value at once, any in-flight engine result is discarded, and no EOT is produced.

Optional Feature:
RETEST_EN
- Defined: the first non-timeout fail in LPBK, CHK or LVL of a test does not report. It goes to PWR with V1ON=V2ON=0 held for PWR_SETTLE cycles, then re-powers and restarts from PWR with a retry flag set.
  - A second fail reports normally. Timeouts are never retried.
  - The retry flag clears on SOT acceptance.
  - During the off period STATE reads PWR.
- Undefined: a fail goes straight to REPORT and no retry logic exists.

Test Plan:
(Bench parameters: PWR_SETTLE=8, PH_TMO=100, BIN_SETUP=4, EOT_LEN=16.)
1. SOT rise, all engines return OK 10 cycles after their GO -> GO pulses in order LPBK, CHK, LVL; V2ON low only in CHK; BIN=5'b00001; EOT high 16 cycles, rising 4 cycles after REPORT entry.
2. LPBK_DN with LPBK_OK=0 -> CHK_GO never pulses; BIN=5'b00010; V1ON=V2ON=0 in REPORT; then EOT.
3. CHK_DN never arrives -> REPORT 100 cycles after CHK entry, BIN=5'b10000. Separately, CHK_DN on the timeout cycle -> normal pass path.
4. Second SOT edge while in LVL and a stray LPBK_DN while in CHK -> no state change; test completes with BIN=5'b00001.
5. RST asserted in LVL -> all outputs 0 immediately; next SOT runs a full test with BIN cleared on PWR entry.
6. With RETEST_EN, LVL fails once and then passes -> two power cycles, one REPORT, BIN=5'b00001. A second consecutive fail -> BIN=5'b01000.

Source files
------------

// File: rtl/tst_seq_ctrl.sv
// Test-flow sequencer for one DUT site.
// On a handler start-of-test it powers the DUT, runs the loopback, checksum and
// level engines in turn, supervises each phase with a timeout, then presents a
// one-hot bin followed by an EOT pulse.
// Optional build macro: RETEST_EN. When defined, the first non-timeout failure
// of a test power-cycles the DUT and reruns the flow once before reporting.
module tst_seq_ctrl #(
    parameter int unsigned      TMO_W      = 24,
    parameter logic [TMO_W-1:0] PH_TMO     = 24'hFF_FFFF,
    parameter logic [TMO_W-1:0] PWR_SETTLE = 24'h00_3FFF,
    parameter logic [TMO_W-1:0] BIN_SETUP  = 24'h00_0040,
    parameter logic [TMO_W-1:0] EOT_LEN    = 24'h07_FFFF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SOT,
    output logic       LPBK_GO,
    input  logic       LPBK_DN,
    input  logic       LPBK_OK,
    output logic       CHK_GO,
    input  logic       CHK_DN,
    input  logic       CHK_OK,
    output logic       LVL_GO,
    input  logic       LVL_DN,
    input  logic       LVL_OK,
    output logic       V1ON,
    output logic       V2ON,
    output logic [4:0] BIN,
    output logic       EOT,
    output logic       BUSY,
    output logic [2:0] STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PWR    = 3'd1,
        S_LPBK   = 3'd2,
        S_CHK    = 3'd3,
        S_LVL    = 3'd4,
        S_REPORT = 3'd5,
        S_EOTS   = 3'd6
    } state_t;

    localparam logic [4:0] BIN_PASS = 5'b00001;
    localparam logic [4:0] BIN_LPBK = 5'b00010;
    localparam logic [4:0] BIN_CHK  = 5'b00100;
    localparam logic [4:0] BIN_LVL  = 5'b01000;
    localparam logic [4:0] BIN_TMO  = 5'b10000;

    localparam logic [TMO_W-1:0] PWR_LAST = PWR_SETTLE - 1'b1;
    localparam logic [TMO_W-1:0] TMO_LAST = PH_TMO - 1'b1;
    localparam logic [TMO_W-1:0] BIN_LAST = BIN_SETUP - 1'b1;
    localparam logic [TMO_W-1:0] EOT_LAST = EOT_LEN - 1'b1;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bin_d;
    logic             v1_d, v2_d, eot_d, busy_d;
    logic             lpbk_go_d, chk_go_d, lvl_go_d;
    logic             cnt_clr;
    logic             fail_ev;
    logic [4:0]       fail_code;

    logic             sot_s1, sot_s2, sot_dly;
    logic             sot_rise;

`ifdef RETEST_EN
    // off_q: DUT supplies held off inside PWR; retry_q: this test already retried
    logic             off_q, off_d;
    logic             retry_q, retry_d;
`endif

    // Two-flop synchroniser plus one delay flop for rising-edge detection of SOT.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sot_s1  <= 1'b0;
            sot_s2  <= 1'b0;
            sot_dly <= 1'b0;
        end else begin
            sot_s1  <= SOT;
            sot_s2  <= sot_s1;
            sot_dly <= sot_s2;
        end
    end

    assign sot_rise = sot_s2 & ~sot_dly;

    // Next-state, phase-result and registered-output decode.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = BIN;
        cnt_clr   = 1'b0;
        fail_ev   = 1'b0;
        fail_code = 5'b00000;
`ifdef RETEST_EN
        off_d     = off_q;
        retry_d   = retry_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (sot_rise) begin
                    state_d = S_PWR;
                    bin_d   = 5'b00000;
`ifdef RETEST_EN
                    retry_d = 1'b0;
`endif
                end
            end
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
`ifdef RETEST_EN
                    if (off_q) begin
                        // Off period over: re-power and settle again from zero.
                        off_d   = 1'b0;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = S_LPBK;
                    end
`else
                    state_d = S_LPBK;
`endif
                end
            end
            S_LPBK: begin
                if (LPBK_DN) begin
                    if (LPBK_OK) state_d = S_CHK;
                    else begin
                        fail_ev   = 1'b1;
                        fail_code = BIN_LPBK;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_REPORT;
                    bin_d   = BIN_TMO;
                end
            end
            S_CHK: begin
                if (CHK_DN) begin
                    if (CHK_OK) state_d = S_LVL;
                    else begin
                        fail_ev   = 1'b1;
                        fail_code = BIN_CHK;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_REPORT;
                    bin_d   = BIN_TMO;
                end
            end
            S_LVL: begin
                if (LVL_DN) begin
                    if (LVL_OK) begin
                        state_d = S_REPORT;
                        bin_d   = BIN_PASS;
                    end else begin
                        fail_ev   = 1'b1;
                        fail_code = BIN_LVL;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = S_REPORT;
                    bin_d   = BIN_TMO;
                end
            end
            S_REPORT: begin
                if (cnt_q == BIN_LAST) state_d = S_EOTS;
            end
            S_EOTS: begin
                if (cnt_q == EOT_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A functional failure either reports at once or, with retest, earns
        // one power-cycled rerun of the whole flow.
        if (fail_ev) begin
`ifdef RETEST_EN
            if (!retry_q) begin
                state_d = S_PWR;
                off_d   = 1'b1;
                retry_d = 1'b1;
            end else begin
                state_d = S_REPORT;
                bin_d   = fail_code;
            end
`else
            state_d = S_REPORT;
            bin_d   = fail_code;
`endif
        end

        cnt_d = (state_d != state_q || cnt_clr) ? '0 : cnt_q + 1'b1;

        // Outputs are decoded from the next state so the registers line up with STATE.
        v1_d      = state_d inside {S_PWR, S_LPBK, S_CHK, S_LVL};
        v2_d      = state_d inside {S_PWR, S_LPBK, S_LVL};
`ifdef RETEST_EN
        if (off_d) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end
`endif
        lpbk_go_d = (state_d == S_LPBK) && (state_q != S_LPBK);
        chk_go_d  = (state_d == S_CHK)  && (state_q != S_CHK);
        lvl_go_d  = (state_d == S_LVL)  && (state_q != S_LVL);
        eot_d     = (state_d == S_EOTS);
        busy_d    = (state_d != S_IDLE);
    end

    // State, shared phase counter and all registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            BIN     <= 5'b00000;
            V1ON    <= 1'b0;
            V2ON    <= 1'b0;
            LPBK_GO <= 1'b0;
            CHK_GO  <= 1'b0;
            LVL_GO  <= 1'b0;
            EOT     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            BIN     <= bin_d;
            V1ON    <= v1_d;
            V2ON    <= v2_d;
            LPBK_GO <= lpbk_go_d;
            CHK_GO  <= chk_go_d;
            LVL_GO  <= lvl_go_d;
            EOT     <= eot_d;
            BUSY    <= busy_d;
        end
    end

`ifdef RETEST_EN
    // Retry bookkeeping: power-off flag and once-per-test retry flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            off_q   <= 1'b0;
            retry_q <= 1'b0;
        end else begin
            off_q   <= off_d;
            retry_q <= retry_d;
        end
    end
`endif

    assign STATE = state_q;

endmodule
